// File: rtl/score_pkg.sv
// Shared types and constants for the score display path: FSM states,
// score ceiling, 7-segment glyphs (bit 0 = a ... bit 6 = g) and a BCD helper.
package score_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_COMMIT  = 2'd2
    } state_e;

    localparam int unsigned SCORE_MAX = 99;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic [1:0] DIG_ONES = 2'b01;
    localparam logic [1:0] DIG_TENS = 2'b10;

    // Double-dabble correction applied to one BCD nibble before each shift.
    function automatic logic [3:0] bcd_add3(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD digit to 7-segment glyph; non-decimal codes go dark.
module seg7_decoder
    import score_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/score_display.sv
// Two-digit multiplexed 7-segment driver for the score: sequential
// double-dabble conversion plus a free-running digit refresh divider.
//
// state      | meaning
// ST_IDLE    | display stable; waiting for value_i to differ from last_val
// ST_CONVERT | one add-3/shift iteration per clock, BW iterations
// ST_COMMIT  | publish digits, last_val and overflow flag
module score_display
    import score_pkg::*;
#(
    parameter int BW          = 7,
    parameter int REFRESH_DIV = 1024,
    parameter int BLANK_LZ    = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [BW-1:0] value_i,
    output logic [6:0]    seg_o,
    output logic [1:0]    dig_sel_o,
    output logic          busy_o,
    output logic          ovf_o
);

    localparam int SR_W = 8 + BW;
    localparam int CW   = (BW > 1) ? $clog2(BW) : 1;
    localparam int RW   = $clog2(REFRESH_DIV);

    state_e          state_q;
    logic [SR_W-1:0] sr_q;
    logic [SR_W-1:0] sr_adj;
    logic [SR_W-1:0] sr_d;
    logic [BW-1:0]   pend_q;
    logic [BW-1:0]   last_q;
    logic [BW-1:0]   bin_sat;
    logic [CW-1:0]   iter_q;
    logic [3:0]      tens_q;
    logic [3:0]      ones_q;
    logic            busy_q;
    logic            ovf_q;

    logic [RW-1:0]   ref_cnt_q;
    logic [RW-1:0]   ref_cnt_d;
    logic [1:0]      dig_sel_q;
    logic [1:0]      dig_sel_d;
    logic            ref_wrap;

    logic [3:0]      digit_mux;
    logic [6:0]      seg_dec;
    logic            blank_tens;

    // Saturating here keeps the tens nibble at 9 or below after conversion.
    always_comb begin
        bin_sat = value_i;
        if (32'(value_i) > SCORE_MAX) begin
            bin_sat = BW'(SCORE_MAX);
        end
    end

    always_comb begin
        sr_adj               = sr_q;
        sr_adj[SR_W-1 -: 4]  = bcd_add3(sr_q[SR_W-1 -: 4]);
        sr_adj[SR_W-5 -: 4]  = bcd_add3(sr_q[SR_W-5 -: 4]);
        sr_d                 = {sr_adj[SR_W-2:0], 1'b0};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            pend_q  <= '0;
            last_q  <= '0;
            iter_q  <= '0;
            tens_q  <= 4'd0;
            ones_q  <= 4'd0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (value_i != last_q) begin
                        sr_q    <= {8'd0, bin_sat};
                        pend_q  <= value_i;
                        iter_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_CONVERT;
                    end
                end
                ST_CONVERT: begin
                    sr_q   <= sr_d;
                    iter_q <= iter_q + CW'(1);
                    if (iter_q == CW'(BW - 1)) begin
                        state_q <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    tens_q  <= sr_q[SR_W-1 -: 4];
                    ones_q  <= sr_q[SR_W-5 -: 4];
                    last_q  <= pend_q;
                    ovf_q   <= (32'(pend_q) > SCORE_MAX);
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Refresh runs independently of conversion; swapping the bits keeps it one-hot.
    always_comb begin
        ref_wrap  = (ref_cnt_q == RW'(REFRESH_DIV - 1));
        ref_cnt_d = ref_wrap ? '0 : ref_cnt_q + RW'(1);
        dig_sel_d = ref_wrap ? {dig_sel_q[0], dig_sel_q[1]} : dig_sel_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ref_cnt_q <= '0;
            dig_sel_q <= DIG_ONES;
        end else begin
            ref_cnt_q <= ref_cnt_d;
            dig_sel_q <= dig_sel_d;
        end
    end

    assign digit_mux  = dig_sel_q[1] ? tens_q : ones_q;
    assign blank_tens = (BLANK_LZ != 0) && dig_sel_q[1] && (tens_q == 4'd0);

    seg7_decoder u_dec (
        .bcd_i (digit_mux),
        .seg_o (seg_dec)
    );

    assign seg_o     = blank_tens ? SEG_BLANK : seg_dec;
    assign dig_sel_o = dig_sel_q;
    assign busy_o    = busy_q;
    assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_score_display.sv
// Directed bench for score_display with a short refresh period so both
// digit phases are reachable within a few clocks.
module tb_score_display;

    localparam logic [6:0] S0 = 7'b0111111;
    localparam logic [6:0] S2 = 7'b1011011;
    localparam logic [6:0] S4 = 7'b1100110;
    localparam logic [6:0] S5 = 7'b1101101;
    localparam logic [6:0] S6 = 7'b1111101;
    localparam logic [6:0] S7 = 7'b0000111;
    localparam logic [6:0] S8 = 7'b1111111;
    localparam logic [6:0] S9 = 7'b1101111;
    localparam logic [6:0] SB = 7'b0000000;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [6:0] value_i;
    logic [6:0] seg_o;
    logic [1:0] dig_sel_o;
    logic       busy_o;
    logic       ovf_o;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    score_display #(.BW(7), .REFRESH_DIV(4), .BLANK_LZ(1)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .value_i   (value_i),
        .seg_o     (seg_o),
        .dig_sel_o (dig_sel_o),
        .busy_o    (busy_o),
        .ovf_o     (ovf_o)
    );

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clk_i);
        while (busy_o === 1'b1 && n < 40) begin
            @(negedge clk_i);
            n++;
        end
        total++;
        if (busy_o !== 1'b0) begin
            bad++;
            $display("FAIL %s_idle_timeout busy=%b required=0", tag, busy_o);
        end
    endtask

    task automatic read_digits(input string tag, output logic [6:0] ones, output logic [6:0] tens);
        int n = 0;
        ones = 'x;
        tens = 'x;
        while (dig_sel_o !== 2'b01 && n < 10) begin
            @(negedge clk_i);
            n++;
        end
        ones = seg_o;
        n = 0;
        while (dig_sel_o !== 2'b10 && n < 10) begin
            @(negedge clk_i);
            n++;
        end
        tens = seg_o;
        total++;
        if (dig_sel_o !== 2'b10) begin
            bad++;
            $display("FAIL %s_phase_timeout dig_sel=%b required=10", tag, dig_sel_o);
        end
    endtask

    task automatic test_reset();
        rst_i   = 1'b1;
        value_i = 7'd0;
        @(negedge clk_i);
        @(negedge clk_i);
        total++; if (busy_o !== 1'b0)     begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        total++; if (dig_sel_o !== 2'b01) begin bad++; $display("FAIL reset_dig_sel got=%b exp=01", dig_sel_o); end
        total++; if (seg_o !== S0)        begin bad++; $display("FAIL reset_seg got=%b exp=%b", seg_o, S0); end
        total++; if (ovf_o !== 1'b0)      begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf_o); end
    endtask

    task automatic test_refresh();
        logic [1:0] exp_sel;
        logic [6:0] exp_seg;
        rst_i = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) @(negedge clk_i);
            exp_sel = (((k / 4) % 2) == 1) ? 2'b10 : 2'b01;
            exp_seg = (exp_sel == 2'b01) ? S0 : SB;
            total++; if (dig_sel_o !== exp_sel) begin bad++; $display("FAIL refresh_sel k=%0d got=%b exp=%b", k, dig_sel_o, exp_sel); end
            total++; if (seg_o !== exp_seg)     begin bad++; $display("FAIL refresh_seg k=%0d got=%b exp=%b", k, seg_o, exp_seg); end
            total++; if (busy_o !== 1'b0)       begin bad++; $display("FAIL refresh_busy k=%0d got=%b exp=0", k, busy_o); end
        end
    endtask

    task automatic test_convert_42();
        logic [6:0] ones, tens;
        logic       exp_busy;
        value_i = 7'd42;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk_i);
            exp_busy = (i <= 8);
            total++;
            if (busy_o !== exp_busy) begin
                bad++;
                $display("FAIL c42_busy edge=%0d got=%b exp=%b", i, busy_o, exp_busy);
            end
        end
        read_digits("c42", ones, tens);
        total++; if (ones !== S2)    begin bad++; $display("FAIL c42_ones got=%b exp=%b", ones, S2); end
        total++; if (tens !== S4)    begin bad++; $display("FAIL c42_tens got=%b exp=%b", tens, S4); end
        total++; if (ovf_o !== 1'b0) begin bad++; $display("FAIL c42_ovf got=%b exp=0", ovf_o); end
    endtask

    task automatic test_saturate();
        logic [6:0] vals [4]  = '{7'd99, 7'd100, 7'd127, 7'd7};
        logic [6:0] eones [4] = '{S9, S9, S9, S7};
        logic [6:0] etens [4] = '{S9, S9, S9, SB};
        logic       eovf [4]  = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [6:0] ones, tens;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            value_i = vals[i];
            wait_idle("sat");
            read_digits("sat", ones, tens);
            total++; if (ones !== eones[i]) begin bad++; $display("FAIL sat_ones v=%0d got=%b exp=%b", vals[i], ones, eones[i]); end
            total++; if (tens !== etens[i]) begin bad++; $display("FAIL sat_tens v=%0d got=%b exp=%b", vals[i], tens, etens[i]); end
            total++; if (ovf_o !== eovf[i]) begin bad++; $display("FAIL sat_ovf v=%0d got=%b exp=%b", vals[i], ovf_o, eovf[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] ones, tens;
        int         busy_seen;
        @(negedge clk_i);
        value_i = 7'd5;
        @(negedge clk_i);
        @(negedge clk_i);
        value_i = 7'd6;
        @(negedge clk_i);
        @(negedge clk_i);
        value_i = 7'd5;
        wait_idle("b2b_a");
        busy_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            if (busy_o !== 1'b0) busy_seen++;
        end
        total++; if (busy_seen != 0) begin bad++; $display("FAIL b2b_stay_idle busy_cycles=%0d exp=0", busy_seen); end
        read_digits("b2b_a", ones, tens);
        total++; if (ones !== S5) begin bad++; $display("FAIL b2b_a_ones got=%b exp=%b", ones, S5); end
        total++; if (tens !== SB) begin bad++; $display("FAIL b2b_a_tens got=%b exp=%b", tens, SB); end

        @(negedge clk_i);
        value_i = 7'd4;
        @(negedge clk_i);
        @(negedge clk_i);
        value_i = 7'd6;
        wait_idle("b2b_b1");
        @(negedge clk_i);
        total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL b2b_restart got=%b exp=1", busy_o); end
        wait_idle("b2b_b2");
        read_digits("b2b_b", ones, tens);
        total++; if (ones !== S6) begin bad++; $display("FAIL b2b_b_ones got=%b exp=%b", ones, S6); end
        total++; if (tens !== SB) begin bad++; $display("FAIL b2b_b_tens got=%b exp=%b", tens, SB); end
    endtask

    task automatic test_reset_mid();
        logic [6:0] ones, tens;
        logic       exp_busy;
        @(negedge clk_i);
        value_i = 7'd0;
        wait_idle("rmid_zero");
        @(negedge clk_i);
        value_i = 7'd88;
        for (int i = 0; i < 4; i++) @(negedge clk_i);
        total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL rmid_pre_busy got=%b exp=1", busy_o); end
        #1 rst_i = 1'b1;
        #1;
        total++; if (busy_o !== 1'b0)     begin bad++; $display("FAIL rmid_busy got=%b exp=0", busy_o); end
        total++; if (dig_sel_o !== 2'b01) begin bad++; $display("FAIL rmid_dig_sel got=%b exp=01", dig_sel_o); end
        total++; if (seg_o !== S0)        begin bad++; $display("FAIL rmid_seg got=%b exp=%b", seg_o, S0); end
        total++; if (ovf_o !== 1'b0)      begin bad++; $display("FAIL rmid_ovf got=%b exp=0", ovf_o); end
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk_i);
            exp_busy = (i <= 8);
            total++;
            if (busy_o !== exp_busy) begin
                bad++;
                $display("FAIL rmid_restart edge=%0d got=%b exp=%b", i, busy_o, exp_busy);
            end
        end
        read_digits("rmid", ones, tens);
        total++; if (ones !== S8) begin bad++; $display("FAIL rmid_ones got=%b exp=%b", ones, S8); end
        total++; if (tens !== S8) begin bad++; $display("FAIL rmid_tens got=%b exp=%b", tens, S8); end
    endtask

    initial begin
        rst_i   = 1'b1;
        value_i = 7'd0;
        test_reset();
        test_refresh();
        test_convert_42();
        test_saturate();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/score_display.md
# score_display

Downstream consumer of the scoreboard counter: takes the 7-bit binary score (0–99) and drives a two-digit multiplexed 7-segment display. Conversion uses a sequential shift-add-3 (double-dabble) engine, one bit per clock. Digit refresh is a free-running divider that alternates the ones and tens digits. The block sits between the counter output and the chip output pins.

## Interface

**Parameters**
- `BW`, default 7: width of the binary input.
- `REFRESH_DIV`, default 1024: clocks per digit-select phase; must be ≥ 2.
- `BLANK_LZ`, default 1: 1 blanks the tens digit when it is 0.

**Ports** (clock and reset first)
- `clk_i`, input, 1: single clock; all state changes on its rising edge.
- `rst_i`, input, 1: asynchronous reset, active-high.
- `value_i`, input, BW: binary score from the counter, sampled every clock.
- `seg_o`, output, 7: segment drive, active-high; `seg_o[0]`=a … `seg_o[6]`=g.
- `dig_sel_o`, output, 2: one-hot digit enable; `2'b01` = ones, `2'b10` = tens.
- `busy_o`, output, 1: high while a conversion is in progress.
- `ovf_o`, output, 1: the committed value was greater than 99 and was saturated.

## Operation

- **State machine states:** IDLE, CONVERT, COMMIT.
- **IDLE:**
  - When `value_i` ≠ `last_val`, load the shift register: BCD part = 0, binary part = min(`value_i`, 99).
  - Latch the raw value into `pend_val`, clear the iteration counter, go to CONVERT.
  - Otherwise stay in IDLE.
- **CONVERT:**
  - Each cycle, add 3 to every BCD nibble that is ≥ 5, then shift the whole register left by 1.
  - Runs exactly BW iterations (7 by default); on the last one, go to COMMIT.
- **COMMIT:**
  - Write the tens and ones digit registers.
  - Set `last_val` = `pend_val`.
  - Set `ovf_o` = (`pend_val` > 99).
  - Go to IDLE.
- **Changes to `value_i` while busy** are ignored. IDLE re-compares on return, so the final settled value is always displayed.
- **Width rule:** the BCD register is 8 bits (two nibbles); the shift register is 8+BW bits. Saturation guarantees tens ≤ 9.
- **Refresh:**
  - `ref_cnt` counts 0..REFRESH_DIV−1 and wraps.
  - On wrap, `dig_sel_o` toggles between 01 and 10.
  - `seg_o` shows the decoded digit for the currently selected position.
- **Blanking:** when `BLANK_LZ`=1, the tens digit = 0 and `dig_sel_o`=10, `seg_o`=0.
- **Segment patterns** (g..a):
  - 0 = 0111111, 1 = 0000110, 2 = 1011011, 3 = 1001111, 4 = 1100110
  - 5 = 1101101, 6 = 1111101, 7 = 0000111, 8 = 1111111, 9 = 1101111

## Timing

- **Reset values:** state IDLE, `last_val` = 0, both digits 0, `ref_cnt` = 0, `dig_sel_o` = 01, `seg_o` = 0111111, `busy_o` = 0, `ovf_o` = 0.
- **Latency:**
  - Edge 1: IDLE detects the change and loads.
  - Edges 2–8: seven shifts.
  - Edge 9: commit.
  - New digits appear on `seg_o` after edge 9 (BW+2 edges in general).
- **`busy_o`:** asserted after edge 1, deasserted after edge 9. It is a registered state decode with no combinational path from `value_i`.
- **Back-to-back changes:** minimum one IDLE cycle between conversions; worst-case update latency is 2×(BW+2)+1 edges.
- **Independent paths:** the refresh path is independent of conversion. A commit mid-phase changes `seg_o` immediately without resetting `ref_cnt`.
- **Reset mid-conversion:** conversion is aborted and all registers take their reset values immediately. After release, a nonzero `value_i` restarts conversion on the first edge.

## Structure

- **Shared package `score_pkg`:**
  - State enum (IDLE/CONVERT/COMMIT).
  - `SCORE_MAX` = 99.
  - Segment pattern constants for digits 0–9.
  - `SEG_BLANK` = 0.
- **Sub-module `seg7_decoder`:** combinational 4-bit BCD → 7-segment decode, using the package constants. Inputs 10–15 map to `SEG_BLANK`.
- **Top:** FSM + shift register, refresh divider, digit mux.

## Test plan

- **Reset release, `value_i` = 0:** no conversion, `busy_o` stays 0, `dig_sel_o` = 01, `seg_o` = 0111111; tens phase gives `seg_o` = 0 (blanked).
- **`value_i` 0→42:** `busy_o` high for 8 cycles. After edge 9: ones phase `seg_o` = 1011011, tens phase `seg_o` = 1100110, `ovf_o` = 0.
- **`value_i` = 99, then 100, then 127:**
  - 99 displays 9/9 with `ovf_o` = 0.
  - 100 and 127 display 9/9 with `ovf_o` = 1.
  - Returning to 7 clears `ovf_o`, displays ones 0000111 and a blanked tens digit.
- **`value_i` 5→6 during CONVERT, then back to 5 before COMMIT:** the first conversion commits 5, the next IDLE sees `last_val` = 5 and stays idle. Repeat with the value settling at 6: a second conversion follows and 6 is displayed.
- **`REFRESH_DIV` = 4:** `dig_sel_o` toggles every 4 clocks (01,01,01,01,10,10,10,10,…) and is never 00 or 11.
- **Assert `rst_i` at CONVERT iteration 3 of a 0→88 conversion:** outputs take their reset values asynchronously. After release with `value_i` = 88, 8/8 is displayed 9 edges later.
